ysyx_23060201_mem_arbiter: RTL

- Two-requester arbiter and sequencer in front of the single-port DPI-C memory block.
- Shares the memory between the IFU (read-only fetch) and the LSU (load/store).
- Serialises accesses, inserts a programmable access latency to emulate SRAM delay, and returns one response per accepted request.
- Sits between IFU/LSU and the memory block; drives its ren/wen strobes, addresses, masks and write data.

---
 rtl/ysyx_23060201_mem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ysyx_23060201_mem_arbiter.sv
// IFU/LSU arbiter that serialises accesses to a single-port memory with a programmable wait latency.
// Optional macro YSYX_23060201_ARB_RR_EN selects round-robin instead of fixed LSU-priority arbitration.
module ysyx_23060201_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [7:0]            lsu_mask,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [7:0]            mem_rmask,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  // state  | meaning
  // IDLE   | no transaction; ready offered to the granted requester
  // WAIT   | latency down-count before the memory access
  // ACCESS | single-cycle ren/wen strobe to memory
  // RESP   | single-cycle resp_valid to the owning requester
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam logic [3:0] C_LOAD      = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [7:0] C_WORD_MASK = 8'((1 << (DATA_WIDTH / 8)) - 1);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_owner_lsu;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [7:0]            r_mask;
  logic [DATA_WIDTH-1:0] r_ifu_rdata;
  logic [DATA_WIDTH-1:0] r_lsu_rdata;

  logic w_grant_lsu;
  logic w_grant_ifu;
  logic w_idle;
  logic w_hs;
  logic w_access;
  logic w_resp;

`ifdef YSYX_23060201_ARB_RR_EN
  logic r_last_lsu;

  // On a tie the side that did not win last time gets the grant.
  assign w_grant_lsu = lsu_req_valid & (~ifu_req_valid | ~r_last_lsu);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_lsu <= 1'b1;
    end else if (w_hs) begin
      r_last_lsu <= w_grant_lsu;
    end
  end
`else
  assign w_grant_lsu = lsu_req_valid;
`endif

  assign w_grant_ifu = ifu_req_valid & ~w_grant_lsu;
  assign w_idle      = (r_state == S_IDLE) & ~rst;
  assign w_hs        = w_idle & (ifu_req_valid | lsu_req_valid);
  assign w_access    = (r_state == S_ACCESS) & ~rst;
  assign w_resp      = (r_state == S_RESP) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_hs) w_next = (LATENCY == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (r_cnt == 4'd0) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready  = w_idle & w_grant_ifu;
    lsu_req_ready  = w_idle & w_grant_lsu;
    mem_ren        = w_access & ~r_wen;
    mem_wen        = w_access & r_wen;
    mem_raddr      = mem_ren ? r_addr : '0;
    mem_rmask      = mem_ren ? r_mask : 8'd0;
    mem_waddr      = mem_wen ? r_addr : '0;
    mem_wdata      = mem_wen ? r_wdata : '0;
    mem_wmask      = mem_wen ? r_mask : 8'd0;
    ifu_resp_valid = w_resp & ~r_owner_lsu;
    lsu_resp_valid = w_resp & r_owner_lsu;
    ifu_rdata      = r_ifu_rdata;
    lsu_rdata      = r_lsu_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_owner_lsu <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mask      <= 8'd0;
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
    end else begin
      if (w_hs) begin
        r_cnt       <= C_LOAD;
        r_owner_lsu <= w_grant_lsu;
        r_wen       <= w_grant_lsu & lsu_wen;
        r_addr      <= w_grant_lsu ? lsu_addr : ifu_addr;
        r_wdata     <= w_grant_lsu ? lsu_wdata : '0;
        r_mask      <= w_grant_lsu ? lsu_mask : C_WORD_MASK;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Read data is captured on the edge that ends ACCESS; a store ack reports zero.
      if (r_state == S_ACCESS) begin
        if (r_wen) begin
          r_lsu_rdata <= '0;
        end else if (r_owner_lsu) begin
          r_lsu_rdata <= mem_rdata;
        end else begin
          r_ifu_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
